overlay_compositor: RTL and testbench

Pixel-output stage directly downstream of the emblem generator. Merges its `draw`/`rgb` overlay onto the background pixel stream with a frame-synchronous fade-in/fade-out state machine. Pipelines pixel and sync signals so they stay aligned, and blanks output outside the active area. Drives the VGA pins.

---
 rtl/overlay_compositor.sv | 171 +++++++++++++++++
 tb/tb_overlay_compositor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/overlay_compositor.sv
// overlay_compositor: merges emblem overlay onto background with frame-synchronous fade; OVERLAY_FADE_EN builds the fade FSM.
// Latency: 2 cycles from inputs to rgb_out/hsync_out/vsync_out, identical for all three.
// Backpressure: none; one pixel accepted and produced every clock.
module overlay_compositor #(
  parameter int FADE_FRAMES     = 8,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       active,
  input  logic [5:0] bg_rgb,
  input  logic       ov_draw,
  input  logic [5:0] ov_rgb,
  input  logic       show,
  output logic [5:0] rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [2:0] fade_level,
  output logic       busy
);

  typedef enum logic [1:0] {HIDDEN, FADE_IN, SHOWN, FADE_OUT} state_t;

  state_t     state, state_nxt;
  logic [2:0] level, level_nxt;

  logic       s1_hs, s1_vs, s1_act, s1_draw;
  logic [5:0] s1_bg, s1_ov;
  logic [2:0] s1_level;
  logic [5:0] blend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HIDDEN;
      level <= 3'd0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

`ifdef OVERLAY_FADE_EN
  localparam int CNT_W = (FADE_FRAMES < 1) ? 1 : $clog2(FADE_FRAMES + 1);

  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  // A show change reverses direction from the current level without stepping it.
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    cnt_nxt   = cnt;
    if (frame_tick) begin
      case (state)
        HIDDEN: begin
          if (show) begin
            state_nxt = FADE_IN;
            cnt_nxt   = '0;
          end
        end
        FADE_IN: begin
          if (!show) begin
            state_nxt = FADE_OUT;
            cnt_nxt   = '0;
          end else if (cnt_inc == CNT_W'(FADE_FRAMES)) begin
            cnt_nxt   = '0;
            level_nxt = level + 3'd1;
            if (level == 3'd3) state_nxt = SHOWN;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        SHOWN: begin
          if (!show) begin
            state_nxt = FADE_OUT;
            cnt_nxt   = '0;
          end
        end
        FADE_OUT: begin
          if (show) begin
            state_nxt = FADE_IN;
            cnt_nxt   = '0;
          end else if (cnt_inc == CNT_W'(FADE_FRAMES)) begin
            cnt_nxt   = '0;
            level_nxt = level - 3'd1;
            if (level == 3'd1) state_nxt = HIDDEN;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = HIDDEN;
      endcase
    end
  end

  assign busy = (state == FADE_IN) || (state == FADE_OUT);

  // Rounded alpha mix of one 2-bit channel; the sum never exceeds 14 so 4 bits suffice.
  function automatic logic [1:0] mix(input logic [1:0] ov, input logic [1:0] bg,
                                     input logic [2:0] l);
    return 2'((4'(ov) * 4'(l) + 4'(bg) * (4'd4 - 4'(l)) + 4'd2) >> 2);
  endfunction

  always_comb begin
    blend = s1_bg;
    if (s1_draw) begin
      blend = {mix(s1_ov[5:4], s1_bg[5:4], s1_level),
               mix(s1_ov[3:2], s1_bg[3:2], s1_level),
               mix(s1_ov[1:0], s1_bg[1:0], s1_level)};
    end
  end
`else
  logic fade_frames_unused;
  assign fade_frames_unused = (FADE_FRAMES >= 1);

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (frame_tick) begin
      state_nxt = show ? SHOWN : HIDDEN;
      level_nxt = show ? 3'd4 : 3'd0;
    end
  end

  assign busy = 1'b0;

  always_comb begin
    blend = s1_bg;
    if (s1_draw && (s1_level == 3'd4)) blend = s1_ov;
  end
`endif

  assign fade_level = level;

  // Stage 1 takes the next level so the pixel sampled on the tick edge already uses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs     <= SYNC_ACTIVE_LOW;
      s1_vs     <= SYNC_ACTIVE_LOW;
      s1_act    <= 1'b0;
      s1_bg     <= 6'd0;
      s1_draw   <= 1'b0;
      s1_ov     <= 6'd0;
      s1_level  <= 3'd0;
      rgb_out   <= 6'd0;
      hsync_out <= SYNC_ACTIVE_LOW;
      vsync_out <= SYNC_ACTIVE_LOW;
    end else begin
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s1_act    <= active;
      s1_bg     <= bg_rgb;
      s1_draw   <= ov_draw;
      s1_ov     <= ov_rgb;
      s1_level  <= level_nxt;
      rgb_out   <= s1_act ? blend : 6'd0;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

endmodule

// File: tb/tb_overlay_compositor.sv
// Scoreboarded bench for overlay_compositor: stimulus queues expected pixels, a negedge monitor compares them.
module tb_overlay_compositor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       active = 1'b0;
  logic [5:0] bg_rgb = 6'd0;
  logic       ov_draw = 1'b0;
  logic [5:0] ov_rgb = 6'd0;
  logic       show = 1'b0;
  logic [5:0] rgb_out;
  logic       hsync_out, vsync_out, busy;
  logic [2:0] fade_level;

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  logic cur_show = 1'b0;

  typedef struct {
    int         due;
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  overlay_compositor #(.FADE_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .active(active),
    .bg_rgb(bg_rgb), .ov_draw(ov_draw), .ov_rgb(ov_rgb), .show(show),
    .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .fade_level(fade_level), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      check("pix_rgb",   rgb_out,   mon_e.rgb);
      check("pix_hsync", hsync_out, mon_e.hs);
      check("pix_vsync", vsync_out, mon_e.vs);
    end
  end

  task automatic drive(input logic t, input logic s, input logic hs, input logic vs,
                       input logic act, input logic [5:0] bg, input logic dr,
                       input logic [5:0] ov, input logic [5:0] exp_rgb);
    exp_t e;
    frame_tick = t; show = s; hsync_in = hs; vsync_in = vs; active = act;
    bg_rgb = bg; ov_draw = dr; ov_rgb = ov;
    e.due = cyc + 2; e.rgb = exp_rgb; e.hs = hs; e.vs = vs;
    q.push_back(e);
  endtask

  task automatic px(input logic t, input logic s, input logic hs, input logic vs,
                    input logic act, input logic [5:0] bg, input logic dr,
                    input logic [5:0] ov, input logic [5:0] exp_rgb);
    @(negedge clk);
    drive(t, s, hs, vs, act, bg, dr, ov, exp_rgb);
  endtask

  task automatic idle(input logic t);
    px(t, cur_show, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00, 6'h00);
  endtask

  task automatic tick_chk(input logic s, input logic [2:0] lv, input logic bz);
    cur_show = s;
    idle(1'b1);
    idle(1'b0);
    check("fade_level", fade_level, lv);
    check("busy", busy, bz);
  endtask

`ifdef OVERLAY_FADE_EN
  logic [2:0] lv_in  [10] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4};
  logic       bz_in  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0] lv_out [9]  = '{3'd4, 3'd4, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
  logic [2:0] lv_rev [7]  = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Three reset cycles with toggling inputs (including an ignored tick), then two blank cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_rgb",   rgb_out,    0);
      check("rst_hsync", hsync_out,  1);
      check("rst_vsync", vsync_out,  1);
      check("rst_level", fade_level, 0);
      check("rst_busy",  busy,       0);
      if (i < 3) begin
        rst = 1'b1; frame_tick = 1'b1; show = 1'b1;
        hsync_in = (i % 2 == 0) ? 1'b0 : 1'b1; vsync_in = (i % 2 == 1) ? 1'b0 : 1'b1;
        active = 1'b1; bg_rgb = 6'h3F; ov_draw = 1'b1; ov_rgb = 6'h15;
      end else begin
        rst = 1'b0;
        if (i == 3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h3F, 1'b0, 6'h00, 6'h3F);
        else        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b100111, 1'b0, 6'h00, 6'b100111);
      end
    end

    // Sync alignment and blanking.
    px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3F, 1'b0, 6'h00, 6'h3F);
    px(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'h3F, 1'b1, 6'h3F, 6'h00);
    px(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b010101, 1'b0, 6'h00, 6'b010101);
    px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000110, 1'b1, 6'h3F, 6'b000110);

`ifdef OVERLAY_FADE_EN
    for (int i = 0; i < 10; i++) begin
      tick_chk(1'b1, lv_in[i], bz_in[i]);
      if (i == 2) px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1, 6'h3F, 6'b010101);
      if (i == 4) begin
        px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1, 6'h3F, 6'b101010);
        px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b110110, 1'b1, 6'b011011, 6'b101011);
      end
    end
    px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b110110, 1'b1, 6'b011011, 6'b011011);
    for (int i = 0; i < 9; i++) tick_chk(1'b0, lv_out[i], (i < 8) ? 1'b1 : 1'b0);
    for (int i = 0; i < 7; i++) tick_chk(1'b1, lv_in[i], 1'b1);
    for (int i = 0; i < 7; i++) tick_chk(1'b0, lv_rev[i], (i < 6) ? 1'b1 : 1'b0);
`else
    // The pixel sampled on the tick edge already sees the new level.
    cur_show = 1'b1;
    px(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h00, 1'b1, 6'b110011, 6'b110011);
    idle(1'b0);
    check("fade_level", fade_level, 4);
    check("busy", busy, 0);
    px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b010010, 1'b1, 6'b101101, 6'b101101);
    px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b010010, 1'b0, 6'b101101, 6'b010010);
    px(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'b010010, 1'b1, 6'b101101, 6'h00);
    tick_chk(1'b0, 3'd0, 1'b0);
    px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'b001100, 1'b1, 6'h3F, 6'b001100);
    cur_show = 1'b1;
    px(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b000011, 1'b1, 6'h3F, 6'b000011);
    idle(1'b0);
    check("level_no_tick", fade_level, 0);
`endif

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
